// File: rtl/freq_selector_acc_if.sv
// AXI-Stream beat for the bin selector: {Q_acc, I_acc} sums, output-set counter in tuser.
interface freq_selector_acc_if #(
  parameter int ACC_W       = 40,
  parameter int FRAME_WIDTH = 21
);
  logic [2*ACC_W-1:0]     tdata;
  logic [FRAME_WIDTH-1:0] tuser;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/freq_selector_acc.sv
// Picks planned bins from a (data,k) stream, integrates each over 2^n frames; match->tvalid is 2 cycles.
// Under backpressure the held beat stays stable and newer beats are dropped with a sticky overflow flag.
module freq_selector_acc #(
  parameter int DATA_WIDTH   = 64,
  parameter int K_WIDTH      = 14,
  parameter int N_SEL_MAX    = 128,
  parameter int IDX_WIDTH    = 7,
  parameter int MAX_LOG2_ACC = 8,
  parameter int FRAME_WIDTH  = 21
) (
  input  logic                  dev_clk,
  input  logic                  reset,
  input  logic                  cfg_enable,
  input  logic                  cfg_we,
  input  logic [IDX_WIDTH-1:0]  cfg_addr,
  input  logic [K_WIDTH-1:0]    cfg_wdata,
  input  logic [IDX_WIDTH:0]    cfg_n_sel,
  input  logic [3:0]            cfg_log2_acc,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [K_WIDTH-1:0]    k_in,
  input  logic                  valid_in,
  freq_selector_acc_if.master   m_axis,
  output logic [IDX_WIDTH-1:0]  index_out,
  output logic                  overflow,
  output logic                  frame_err
);
  localparam int HALF  = DATA_WIDTH / 2;
  localparam int ACC_W = HALF + MAX_LOG2_ACC;
  localparam logic [IDX_WIDTH:0] ONE      = {{IDX_WIDTH{1'b0}}, 1'b1};
  localparam logic [IDX_WIDTH:0] SEL_MAX  = (IDX_WIDTH+1)'(N_SEL_MAX);
  localparam logic [3:0]         LOG2_MAX = 4'(MAX_LOG2_ACC);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  state_t state;

  logic [K_WIDTH-1:0]      plan  [N_SEL_MAX];
  logic signed [ACC_W-1:0] acc_i [N_SEL_MAX];
  logic signed [ACC_W-1:0] acc_q [N_SEL_MAX];

  logic [IDX_WIDTH:0]      n_sel, ptr, ptr_eff;
  logic [3:0]              log2_acc;
  logic [MAX_LOG2_ACC-1:0] acc_cnt, acc_mask, cnt_eff;
  logic [FRAME_WIDTH-1:0]  set_cnt;
  logic                    frame_start, go, match;

  logic                    s1_vld, s1_first, s1_last, s1_tlast;
  logic [IDX_WIDTH-1:0]    s1_ptr;
  logic signed [HALF-1:0]  s1_i, s1_q;

  logic signed [ACC_W-1:0] ext_i, ext_q, sum_i, sum_q;
  logic                    s2_fire, emit, busy;

  // A k==0 sample both closes the old frame and belongs to the new one, so it is matched at ptr 0.
  always_comb begin
    acc_mask    = ~({MAX_LOG2_ACC{1'b1}} << log2_acc);
    frame_start = valid_in && (k_in == '0);
    go          = cfg_enable && valid_in && ((state == RUN) || (state == ARMED && frame_start));
    ptr_eff     = frame_start ? '0 : ptr;
    cnt_eff     = (state == ARMED) ? '0
                : (frame_start ? ((acc_cnt + 1'b1) & acc_mask) : acc_cnt);
    match       = go && (ptr_eff < n_sel) && (k_in == plan[ptr_eff[IDX_WIDTH-1:0]]);
  end

  always_comb begin
    ext_i   = {{MAX_LOG2_ACC{s1_i[HALF-1]}}, s1_i};
    ext_q   = {{MAX_LOG2_ACC{s1_q[HALF-1]}}, s1_q};
    sum_i   = (s1_first ? '0 : acc_i[s1_ptr]) + ext_i;
    sum_q   = (s1_first ? '0 : acc_q[s1_ptr]) + ext_q;
    s2_fire = s1_vld && cfg_enable;
    emit    = s2_fire && s1_last;
    busy    = m_axis.tvalid && !m_axis.tready;
  end

  always_ff @(posedge dev_clk) begin
    if (!reset && state == IDLE && cfg_we)
      plan[cfg_addr] <= cfg_wdata;
    if (!reset && s2_fire && !s1_last) begin
      acc_i[s1_ptr] <= sum_i;
      acc_q[s1_ptr] <= sum_q;
    end
  end

  always_ff @(posedge dev_clk) begin
    if (reset) begin
      state         <= IDLE;
      n_sel         <= '0;
      log2_acc      <= '0;
      ptr           <= '0;
      acc_cnt       <= '0;
      set_cnt       <= '0;
      s1_vld        <= 1'b0;
      s1_first      <= 1'b0;
      s1_last       <= 1'b0;
      s1_tlast      <= 1'b0;
      s1_ptr        <= '0;
      s1_i          <= '0;
      s1_q          <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tlast  <= 1'b0;
      index_out     <= '0;
      overflow      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          n_sel    <= (cfg_n_sel > SEL_MAX) ? SEL_MAX : cfg_n_sel;
          log2_acc <= (cfg_log2_acc > LOG2_MAX) ? LOG2_MAX : cfg_log2_acc;
          if (cfg_enable) begin
            state     <= ARMED;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
          end
        end
        ARMED: begin
          if (!cfg_enable)      state <= IDLE;
          else if (frame_start) state <= RUN;
        end
        RUN: begin
          if (!cfg_enable)                       state     <= IDLE;
          else if (frame_start && ptr != n_sel)  frame_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (go) begin
        ptr <= match ? ptr_eff + ONE : ptr_eff;
        if (frame_start) acc_cnt <= cnt_eff;
      end

      s1_vld <= match;
      if (match) begin
        s1_i     <= data_in[HALF-1:0];
        s1_q     <= data_in[DATA_WIDTH-1:HALF];
        s1_ptr   <= ptr_eff[IDX_WIDTH-1:0];
        s1_first <= (cnt_eff == '0);
        s1_last  <= (cnt_eff == acc_mask);
        s1_tlast <= (ptr_eff == n_sel - ONE);
      end

      // The held beat is never overwritten; a beat arriving behind it is lost.
      if (emit && !busy) begin
        m_axis.tvalid <= 1'b1;
        m_axis.tdata  <= {sum_q, sum_i};
        m_axis.tlast  <= s1_tlast;
        index_out     <= s1_ptr;
      end else begin
        if (emit)          overflow      <= 1'b1;
        if (m_axis.tready) m_axis.tvalid <= 1'b0;
      end

      if (m_axis.tvalid && m_axis.tready && m_axis.tlast)
        set_cnt <= set_cnt + 1'b1;
    end
  end

  assign m_axis.tuser = set_cnt;
endmodule
